phase_arbiter: RTL and testbench

Shares one phase (atan) unit between the two per-antenna short-preamble synchronizers, so the dual-antenna receive path needs only one phase unit instead of two. Each requester issues fire-and-forget {I,Q} strobes with no backpressure; the arbiter queues, round-robin grants and tags each issue. It routes in-order phase results back to the originating requester. It sits between the dual sync_short instances and a single phase instance.

---
 rtl/phase_arbiter_pkg.sv | 14 +
 rtl/phase_arb_fifo.sv | 50 +++++
 rtl/phase_arbiter.sv | 158 +++++++++++++++
 tb/tb_phase_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/phase_arbiter_pkg.sv
// Shared constants for the dual-antenna phase arbiter: requester tags and tag width.
package phase_arbiter_pkg;

  localparam int unsigned TAG_W = 1;

  localparam logic [TAG_W-1:0] REQ_ANT1 = 1'b0;
  localparam logic [TAG_W-1:0] REQ_ANT2 = 1'b1;

  // Round-robin partner of a requester tag
  function automatic logic [TAG_W-1:0] other_req(input logic [TAG_W-1:0] tag);
    return (tag == REQ_ANT1) ? REQ_ANT2 : REQ_ANT1;
  endfunction

endpackage

// File: rtl/phase_arb_fifo.sv
// Generic synchronous first-word-fall-through FIFO with full/empty/count flags.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module phase_arb_fifo #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_din,
  output logic [WIDTH-1:0]         o_dout_c,
  output logic                     o_full_c,
  output logic                     o_empty_c,
  output logic [$clog2(DEPTH):0]   o_count_c
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_push;
  logic             w_do_pop;

  always_comb begin
    o_count_c = r_wr_ptr - r_rd_ptr;
    o_empty_c = (o_count_c == '0);
    o_full_c  = (o_count_c == (AW+1)'(DEPTH));
    o_dout_c  = r_mem[r_rd_ptr[AW-1:0]];
    w_do_pop  = i_pop && !o_empty_c;
    w_do_push = i_push && (!o_full_c || w_do_pop);
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // Storage carries no reset; validity is tracked by the pointers
  always_ff @(posedge i_clock) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
  end

endmodule

// File: rtl/phase_arbiter.sv
// Shares one phase unit between two antenna synchronizers: queues, round-robin grants, tags, routes results.
// Optional PHASE_ARB_STATS_EN adds grant and stall counters.
module phase_arbiter #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned QDEPTH       = 2,
  parameter int unsigned MAX_INFLIGHT = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] req_i_1,
  input  logic [DATA_WIDTH-1:0] req_q_1,
  input  logic                  req_stb_1,
  input  logic [DATA_WIDTH-1:0] req_i_2,
  input  logic [DATA_WIDTH-1:0] req_q_2,
  input  logic                  req_stb_2,
  output logic [DATA_WIDTH-1:0] phase_in_i,
  output logic [DATA_WIDTH-1:0] phase_in_q,
  output logic                  phase_in_stb,
  input  logic [DATA_WIDTH-1:0] phase_out,
  input  logic                  phase_out_stb,
  output logic [DATA_WIDTH-1:0] rsp_phase_1,
  output logic [DATA_WIDTH-1:0] rsp_phase_2,
  output logic                  rsp_stb_1,
  output logic                  rsp_stb_2,
  output logic [1:0]            err_overflow,
  output logic                  err_orphan
`ifdef PHASE_ARB_STATS_EN
  ,
  output logic [15:0]           grant_cnt_1,
  output logic [15:0]           grant_cnt_2,
  output logic [15:0]           stall_cnt
`endif
);

  import phase_arbiter_pkg::*;

  localparam int unsigned PW  = 2 * DATA_WIDTH;
  localparam int unsigned QCW = $clog2(QDEPTH) + 1;
  localparam int unsigned TCW = $clog2(MAX_INFLIGHT) + 1;

  logic [PW-1:0]    w_q1_dout;
  logic [PW-1:0]    w_q2_dout;
  logic             w_q1_full, w_q1_empty;
  logic             w_q2_full, w_q2_empty;
  logic [QCW-1:0]   w_q1_cnt, w_q2_cnt;
  logic [TAG_W-1:0] w_tag_dout;
  logic             w_tag_full, w_tag_empty;
  logic [TCW-1:0]   w_tag_cnt;
  logic             w_unused_cnt;

  logic             w_elig1, w_elig2;
  logic             w_gnt1, w_gnt2, w_any_gnt;
  logic [TAG_W-1:0] w_gnt_tag;
  logic [PW-1:0]    w_issue_data;
  logic             w_rsp_pop, w_orphan;
  logic [1:0]       w_ovf;

  logic [TAG_W-1:0] r_rr_next;

  assign w_unused_cnt = ^{w_q1_cnt, w_q2_cnt, w_tag_cnt};

  // Request queues and the in-order tag FIFO
  phase_arb_fifo #(.WIDTH(PW), .DEPTH(QDEPTH)) u_q1 (
    .i_clock  (clock),
    .i_reset  (reset),
    .i_push   (req_stb_1),
    .i_pop    (w_gnt1),
    .i_din    ({req_i_1, req_q_1}),
    .o_dout_c (w_q1_dout),
    .o_full_c (w_q1_full),
    .o_empty_c(w_q1_empty),
    .o_count_c(w_q1_cnt)
  );

  phase_arb_fifo #(.WIDTH(PW), .DEPTH(QDEPTH)) u_q2 (
    .i_clock  (clock),
    .i_reset  (reset),
    .i_push   (req_stb_2),
    .i_pop    (w_gnt2),
    .i_din    ({req_i_2, req_q_2}),
    .o_dout_c (w_q2_dout),
    .o_full_c (w_q2_full),
    .o_empty_c(w_q2_empty),
    .o_count_c(w_q2_cnt)
  );

  phase_arb_fifo #(.WIDTH(TAG_W), .DEPTH(MAX_INFLIGHT)) u_tag (
    .i_clock  (clock),
    .i_reset  (reset),
    .i_push   (w_any_gnt),
    .i_pop    (w_rsp_pop),
    .i_din    (w_gnt_tag),
    .o_dout_c (w_tag_dout),
    .o_full_c (w_tag_full),
    .o_empty_c(w_tag_empty),
    .o_count_c(w_tag_cnt)
  );

  // Grant selection; a full tag FIFO means MAX_INFLIGHT operations are outstanding
  always_comb begin
    w_elig1      = enable && !w_q1_empty && !w_tag_full;
    w_elig2      = enable && !w_q2_empty && !w_tag_full;
    w_gnt1       = w_elig1 && (!w_elig2 || (r_rr_next == REQ_ANT1));
    w_gnt2       = w_elig2 && (!w_elig1 || (r_rr_next == REQ_ANT2));
    w_any_gnt    = w_gnt1 || w_gnt2;
    w_gnt_tag    = w_gnt2 ? REQ_ANT2 : REQ_ANT1;
    w_issue_data = w_gnt2 ? w_q2_dout : w_q1_dout;
    w_rsp_pop    = phase_out_stb && !w_tag_empty;
    w_orphan     = phase_out_stb && w_tag_empty;
    w_ovf[0]     = req_stb_1 && w_q1_full && !w_gnt1;
    w_ovf[1]     = req_stb_2 && w_q2_full && !w_gnt2;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      phase_in_i   <= '0;
      phase_in_q   <= '0;
      phase_in_stb <= 1'b0;
      rsp_phase_1  <= '0;
      rsp_phase_2  <= '0;
      rsp_stb_1    <= 1'b0;
      rsp_stb_2    <= 1'b0;
      err_overflow <= 2'b00;
      err_orphan   <= 1'b0;
      r_rr_next    <= REQ_ANT1;
    end else begin
      phase_in_stb <= w_any_gnt;
      if (w_any_gnt) begin
        phase_in_i <= w_issue_data[PW-1:DATA_WIDTH];
        phase_in_q <= w_issue_data[DATA_WIDTH-1:0];
        r_rr_next  <= other_req(w_gnt_tag);
      end
      rsp_stb_1 <= w_rsp_pop && (w_tag_dout == REQ_ANT1);
      rsp_stb_2 <= w_rsp_pop && (w_tag_dout == REQ_ANT2);
      if (w_rsp_pop && (w_tag_dout == REQ_ANT1)) rsp_phase_1 <= phase_out;
      if (w_rsp_pop && (w_tag_dout == REQ_ANT2)) rsp_phase_2 <= phase_out;
      err_overflow <= err_overflow | w_ovf;
      err_orphan   <= err_orphan | w_orphan;
    end
  end

`ifdef PHASE_ARB_STATS_EN
  // Stall: work is queued but nothing was granted this cycle
  always_ff @(posedge clock) begin
    if (!reset) begin
      grant_cnt_1 <= 16'd0;
      grant_cnt_2 <= 16'd0;
      stall_cnt   <= 16'd0;
    end else begin
      if (w_gnt1) grant_cnt_1 <= grant_cnt_1 + 16'd1;
      if (w_gnt2) grant_cnt_2 <= grant_cnt_2 + 16'd1;
      if ((!w_q1_empty || !w_q2_empty) && !w_any_gnt) stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_phase_arbiter.sv
// Self-checking bench for phase_arbiter against a queue-based reference model.
// Also checks the statistics counters when PHASE_ARB_STATS_EN is defined.
module tb_phase_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned QD = 2;
  localparam int unsigned MI = 8;

  logic          clock = 1'b0;
  logic          reset, enable;
  logic [DW-1:0] req_i_1, req_q_1, req_i_2, req_q_2;
  logic          req_stb_1, req_stb_2;
  logic [DW-1:0] phase_in_i, phase_in_q;
  logic          phase_in_stb;
  logic [DW-1:0] phase_out;
  logic          phase_out_stb;
  logic [DW-1:0] rsp_phase_1, rsp_phase_2;
  logic          rsp_stb_1, rsp_stb_2;
  logic [1:0]    err_overflow;
  logic          err_orphan;
`ifdef PHASE_ARB_STATS_EN
  logic [15:0]   grant_cnt_1, grant_cnt_2, stall_cnt;
`endif

  always #5 clock = ~clock;

  phase_arbiter #(.DATA_WIDTH(DW), .QDEPTH(QD), .MAX_INFLIGHT(MI)) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .req_i_1      (req_i_1),
    .req_q_1      (req_q_1),
    .req_stb_1    (req_stb_1),
    .req_i_2      (req_i_2),
    .req_q_2      (req_q_2),
    .req_stb_2    (req_stb_2),
    .phase_in_i   (phase_in_i),
    .phase_in_q   (phase_in_q),
    .phase_in_stb (phase_in_stb),
    .phase_out    (phase_out),
    .phase_out_stb(phase_out_stb),
    .rsp_phase_1  (rsp_phase_1),
    .rsp_phase_2  (rsp_phase_2),
    .rsp_stb_1    (rsp_stb_1),
    .rsp_stb_2    (rsp_stb_2),
    .err_overflow (err_overflow),
    .err_orphan   (err_orphan)
`ifdef PHASE_ARB_STATS_EN
    ,
    .grant_cnt_1  (grant_cnt_1),
    .grant_cnt_2  (grant_cnt_2),
    .stall_cnt    (stall_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: behavioural queues, tag order, round-robin preference
  logic [2*DW-1:0] m_q1 [$];
  logic [2*DW-1:0] m_q2 [$];
  bit              m_tag [$];
  bit              m_rr;
  logic [15:0]     m_g1, m_g2, m_stall;

  logic          e_in_stb, e_rsp_stb1, e_rsp_stb2, e_orph;
  logic [DW-1:0] e_in_i, e_in_q, e_rsp1, e_rsp2;
  logic [1:0]    e_ovf;

  logic [133:0] obs_vec, exp_vec;
  assign obs_vec = {phase_in_stb, phase_in_i, phase_in_q, rsp_stb_1, rsp_phase_1,
                    rsp_stb_2, rsp_phase_2, err_overflow, err_orphan};
  assign exp_vec = {e_in_stb, e_in_i, e_in_q, e_rsp_stb1, e_rsp1,
                    e_rsp_stb2, e_rsp2, e_ovf, e_orph};

  // Advance model by one cycle using the inputs seen at this edge, then move past the edge
  task automatic tick();
    bit el1, el2, t;
    int g;
    logic [2*DW-1:0] d;
    g = -1;
    if (!reset) begin
      m_q1.delete(); m_q2.delete(); m_tag.delete();
      m_rr = 1'b0;
      m_g1 = '0; m_g2 = '0; m_stall = '0;
      e_in_stb = 0; e_in_i = '0; e_in_q = '0;
      e_rsp_stb1 = 0; e_rsp_stb2 = 0; e_rsp1 = '0; e_rsp2 = '0;
      e_ovf = 2'b00; e_orph = 0;
    end else begin
      el1 = enable && (m_q1.size() != 0) && (m_tag.size() < MI);
      el2 = enable && (m_q2.size() != 0) && (m_tag.size() < MI);
      if (el1 && el2) g = int'(m_rr);
      else if (el1) g = 0;
      else if (el2) g = 1;
      if ((m_q1.size() != 0 || m_q2.size() != 0) && g < 0) m_stall = m_stall + 16'd1;
      e_rsp_stb1 = 0; e_rsp_stb2 = 0;
      if (phase_out_stb) begin
        if (m_tag.size() != 0) begin
          t = m_tag.pop_front();
          if (!t) begin e_rsp_stb1 = 1; e_rsp1 = phase_out; end
          else    begin e_rsp_stb2 = 1; e_rsp2 = phase_out; end
        end else e_orph = 1;
      end
      e_in_stb = 0;
      if (g >= 0) begin
        if (g == 0) begin d = m_q1.pop_front(); m_g1 = m_g1 + 16'd1; end
        else        begin d = m_q2.pop_front(); m_g2 = m_g2 + 16'd1; end
        e_in_stb = 1; e_in_i = d[2*DW-1:DW]; e_in_q = d[DW-1:0];
        m_tag.push_back(g == 1);
        m_rr = (g == 0);
      end
      if (req_stb_1) begin
        if (m_q1.size() < QD) m_q1.push_back({req_i_1, req_q_1}); else e_ovf[0] = 1;
      end
      if (req_stb_2) begin
        if (m_q2.size() < QD) m_q2.push_back({req_i_2, req_q_2}); else e_ovf[1] = 1;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_reset();
    req_stb_1 = 0; req_stb_2 = 0; phase_out_stb = 0; enable = 1;
    reset = 0; tick(); reset = 1;
  endtask

  task automatic test_reset();
    reset = 0; tick(); tick();
    checks++;
    if (obs_vec !== 134'd0) begin
      errors++; $display("FAIL reset_outputs got=%h exp=0", obs_vec);
    end
    reset = 1;
  endtask

  task automatic test_single();
    req_i_1 = 32'h3; req_q_1 = 32'h4; req_stb_1 = 1;
    tick(); req_stb_1 = 0;
    checks++;
    if (phase_in_stb !== 1'b0) begin errors++; $display("FAIL single_early stb=%b exp=0", phase_in_stb); end
    tick();
    checks++;
    if ({phase_in_stb, phase_in_i, phase_in_q} !== {1'b1, 32'h3, 32'h4}) begin
      errors++; $display("FAIL single_issue got=%b/%h/%h exp=1/3/4", phase_in_stb, phase_in_i, phase_in_q);
    end
    tick();
    checks++;
    if (phase_in_stb !== 1'b0) begin errors++; $display("FAIL single_pulse stb=%b exp=0", phase_in_stb); end
    phase_out = 32'h1234; phase_out_stb = 1;
    tick(); phase_out_stb = 0;
    checks++;
    if ({rsp_stb_1, rsp_phase_1, rsp_stb_2} !== {1'b1, 32'h1234, 1'b0}) begin
      errors++; $display("FAIL single_rsp got=%b/%h/%b exp=1/1234/0", rsp_stb_1, rsp_phase_1, rsp_stb_2);
    end
    checks++;
    if (obs_vec !== exp_vec) begin errors++; $display("FAIL single_model got=%h exp=%h", obs_vec, exp_vec); end
  endtask

  task automatic test_simultaneous();
    logic [DW-1:0] a_i, a_q, b_i, b_q, r1, r2;
    pulse_reset();
    a_i = $urandom; a_q = $urandom; b_i = $urandom; b_q = $urandom;
    r1 = $urandom; r2 = $urandom;
    req_i_1 = a_i; req_q_1 = a_q; req_i_2 = b_i; req_q_2 = b_q;
    req_stb_1 = 1; req_stb_2 = 1;
    tick(); req_stb_1 = 0; req_stb_2 = 0;
    tick();
    checks++;
    if ({phase_in_stb, phase_in_i, phase_in_q} !== {1'b1, a_i, a_q}) begin
      errors++; $display("FAIL simul_first got=%b/%h/%h exp=1/%h/%h", phase_in_stb, phase_in_i, phase_in_q, a_i, a_q);
    end
    phase_out = r1; phase_out_stb = 1;
    tick();
    checks++;
    if ({phase_in_stb, phase_in_i, phase_in_q} !== {1'b1, b_i, b_q}) begin
      errors++; $display("FAIL simul_second got=%b/%h/%h exp=1/%h/%h", phase_in_stb, phase_in_i, phase_in_q, b_i, b_q);
    end
    checks++;
    if ({rsp_stb_1, rsp_phase_1, rsp_stb_2} !== {1'b1, r1, 1'b0}) begin
      errors++; $display("FAIL simul_rsp1 got=%b/%h/%b exp=1/%h/0", rsp_stb_1, rsp_phase_1, rsp_stb_2, r1);
    end
    phase_out = r2;
    tick(); phase_out_stb = 0;
    checks++;
    if ({rsp_stb_2, rsp_phase_2, rsp_stb_1} !== {1'b1, r2, 1'b0}) begin
      errors++; $display("FAIL simul_rsp2 got=%b/%h/%b exp=1/%h/0", rsp_stb_2, rsp_phase_2, rsp_stb_1, r2);
    end
  endtask

  task automatic test_fairness();
    logic [3:0] src, exp_src;
    exp_src = 4'h1;
    pulse_reset();
    for (int c = 0; c < 28; c++) begin
      req_stb_1 = (c < 20); req_stb_2 = (c < 20);
      req_i_1 = {4'h1, 28'(c)}; req_q_1 = $urandom;
      req_i_2 = {4'h2, 28'(c)}; req_q_2 = $urandom;
      phase_out = $urandom; phase_out_stb = (m_tag.size() != 0);
      tick();
      checks++;
      if (obs_vec !== exp_vec) begin errors++; $display("FAIL fair_model c=%0d got=%h exp=%h", c, obs_vec, exp_vec); end
      if (phase_in_stb === 1'b1) begin
        src = phase_in_i[DW-1:DW-4];
        checks++;
        if (src !== exp_src) begin errors++; $display("FAIL fair_order c=%0d src=%0d exp=%0d", c, src, exp_src); end
        exp_src = (exp_src == 4'h1) ? 4'h2 : 4'h1;
      end
      if (c == 20) begin
        checks++;
        if (err_overflow !== 2'b11) begin errors++; $display("FAIL fair_overflow got=%b exp=11", err_overflow); end
      end
    end
    req_stb_1 = 0; req_stb_2 = 0; phase_out_stb = 0;
  endtask

  task automatic test_backpressure();
    int pulses;
    pulses = 0;
    pulse_reset();
    for (int c = 0; c < 22; c++) begin
      req_stb_1 = (c < 10); req_i_1 = 32'(c + 1); req_q_1 = $urandom;
      phase_out_stb = 0;
      tick();
      checks++;
      if (obs_vec !== exp_vec) begin errors++; $display("FAIL bp_model c=%0d got=%h exp=%h", c, obs_vec, exp_vec); end
      if (phase_in_stb === 1'b1) pulses++;
    end
    req_stb_1 = 0;
    checks++;
    if (pulses !== 8) begin errors++; $display("FAIL bp_pulses got=%0d exp=8", pulses); end
    phase_out = $urandom; phase_out_stb = 1;
    tick(); phase_out_stb = 0;
    checks++;
    if ({rsp_stb_1, phase_in_stb} !== 2'b10) begin
      errors++; $display("FAIL bp_rsp got rsp=%b issue=%b exp rsp=1 issue=0", rsp_stb_1, phase_in_stb);
    end
    tick();
    checks++;
    if ({phase_in_stb, phase_in_i} !== {1'b1, 32'd9}) begin
      errors++; $display("FAIL bp_ninth got=%b/%h exp=1/9", phase_in_stb, phase_in_i);
    end
    for (int c = 0; c < 14; c++) begin
      phase_out = $urandom; phase_out_stb = (m_tag.size() != 0) && ($urandom_range(0, 3) != 0);
      tick();
      checks++;
      if (obs_vec !== exp_vec) begin errors++; $display("FAIL bp_drain c=%0d got=%h exp=%h", c, obs_vec, exp_vec); end
    end
    phase_out_stb = 0;
  endtask

  task automatic test_orphan_enable();
    logic [DW-1:0] d_i, d_q, r;
    pulse_reset();
    phase_out = $urandom; phase_out_stb = 1;
    tick(); phase_out_stb = 0;
    checks++;
    if ({rsp_stb_1, rsp_stb_2, err_orphan} !== 3'b001) begin
      errors++; $display("FAIL orphan_flag got rsp1=%b rsp2=%b orph=%b exp 0/0/1", rsp_stb_1, rsp_stb_2, err_orphan);
    end
    d_i = $urandom; d_q = $urandom;
    enable = 0; req_i_2 = d_i; req_q_2 = d_q; req_stb_2 = 1;
    tick(); req_stb_2 = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (phase_in_stb !== 1'b0) begin errors++; $display("FAIL enable_hold c=%0d stb=%b exp=0", c, phase_in_stb); end
    end
    enable = 1;
    tick();
    checks++;
    if ({phase_in_stb, phase_in_i, phase_in_q} !== {1'b1, d_i, d_q}) begin
      errors++; $display("FAIL enable_issue got=%b/%h/%h exp=1/%h/%h", phase_in_stb, phase_in_i, phase_in_q, d_i, d_q);
    end
    enable = 0; r = $urandom; phase_out = r; phase_out_stb = 1;
    tick(); phase_out_stb = 0;
    checks++;
    if ({rsp_stb_2, rsp_phase_2, rsp_stb_1, err_orphan} !== {1'b1, r, 1'b0, 1'b1}) begin
      errors++; $display("FAIL disabled_route got=%b/%h/%b/%b exp=1/%h/0/1", rsp_stb_2, rsp_phase_2, rsp_stb_1, err_orphan, r);
    end
    enable = 1;
  endtask

  task automatic test_reset_midflight();
    logic [DW-1:0] a_i, b_i;
    pulse_reset();
    enable = 0;
    for (int c = 0; c < 3; c++) begin
      req_i_2 = $urandom; req_q_2 = $urandom; req_stb_2 = 1;
      tick();
    end
    req_stb_2 = 0; enable = 1;
    req_i_1 = $urandom; req_q_1 = $urandom; req_stb_1 = 1;
    tick(); req_stb_1 = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (obs_vec !== exp_vec) begin errors++; $display("FAIL mid_model c=%0d got=%h exp=%h", c, obs_vec, exp_vec); end
    end
    reset = 0; tick(); reset = 1;
    checks++;
    if (obs_vec !== 134'd0) begin errors++; $display("FAIL mid_reset_clear got=%h exp=0", obs_vec); end
    a_i = $urandom; b_i = $urandom;
    req_i_1 = a_i; req_q_1 = $urandom; req_i_2 = b_i; req_q_2 = $urandom;
    req_stb_1 = 1; req_stb_2 = 1;
    tick(); req_stb_1 = 0; req_stb_2 = 0;
    tick();
    checks++;
    if ({phase_in_stb, phase_in_i} !== {1'b1, a_i}) begin
      errors++; $display("FAIL mid_pointer got=%b/%h exp=1/%h", phase_in_stb, phase_in_i, a_i);
    end
    for (int c = 0; c < 6; c++) begin
      phase_out = $urandom; phase_out_stb = (m_tag.size() != 0);
      tick();
      checks++;
      if (obs_vec !== exp_vec) begin errors++; $display("FAIL mid_drain c=%0d got=%h exp=%h", c, obs_vec, exp_vec); end
    end
    phase_out_stb = 0;
`ifdef PHASE_ARB_STATS_EN
    checks++;
    if ({grant_cnt_1, grant_cnt_2, stall_cnt} !== {m_g1, m_g2, m_stall}) begin
      errors++; $display("FAIL stats got=%h/%h/%h exp=%h/%h/%h", grant_cnt_1, grant_cnt_2, stall_cnt, m_g1, m_g2, m_stall);
    end
`endif
  endtask

  initial begin
    reset = 0; enable = 1;
    req_i_1 = '0; req_q_1 = '0; req_stb_1 = 0;
    req_i_2 = '0; req_q_2 = '0; req_stb_2 = 0;
    phase_out = '0; phase_out_stb = 0;
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_backpressure();
    test_orphan_enable();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
